// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parametrised PISO serializer.
// Holds the FSM state encoding and the counter-width helper.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // A one-bit counter is still needed for the smallest legal WIDTH.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Counts consumed bits of the current frame and flags the final bit position.
// Clear takes priority over increment so a reload on the last bit restarts at zero.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = clog2_min1(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, per-word direction and stall.
// A new word may be accepted on the last-bit cycle so frames run back to back.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done,
    output logic             busy
);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg;
    logic             dir_q;
    logic             last;
    logic             consume;
    logic             accept;
    logic             last_consume;

    assign consume      = (state_q == SHIFT) && shift_en;
    assign last_consume = consume && last;
    assign load_ready   = (state_q == IDLE) || last_consume;
    assign accept       = load_valid && load_ready;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept || last_consume),
        .inc  (consume),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_consume) begin
                    state_d = accept ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reload wins over the shift that retires the previous word's last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            dir_q      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_consume;
            if (accept) begin
                shreg <= din;
                dir_q <= lsb_first;
            end else if (consume) begin
                shreg <= dir_q ? (shreg >> 1) : (shreg << 1);
            end
        end
    end

    assign serial_valid = (state_q == SHIFT);
    assign busy         = serial_valid;
    assign serial_out   = (state_q == IDLE) ? IDLE_LEVEL
                        : (dir_q ? shreg[0] : shreg[WIDTH-1]);

endmodule
